// File: rtl/input_mems_pkg.sv
// Shared sizes, FSM state types and K clamping for the ping-pong operand store.
package input_mems_pkg;

    localparam int unsigned INW         = 12;
    localparam int unsigned M           = 7;
    localparam int unsigned N           = 9;
    localparam int unsigned MAXK        = 8;
    localparam int unsigned K_BITS      = $clog2(MAXK + 1);
    localparam int unsigned A_ADDR_BITS = $clog2(M * MAXK);
    localparam int unsigned B_ADDR_BITS = $clog2(MAXK * N);
    localparam int unsigned CNT_BITS    = (A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS;

    typedef enum logic [1:0] {W_IDLE, W_A, W_B} wstate_e;
    typedef enum logic       {R_EMPTY, R_LOADED} rstate_e;

    // K=0 is treated as 1 and anything above MAXK saturates.
    function automatic logic [K_BITS-1:0] clamp_k(input logic [K_BITS-1:0] k);
        if (k == '0) begin
            return K_BITS'(1);
        end else if (k > K_BITS'(MAXK)) begin
            return K_BITS'(MAXK);
        end
        return k;
    endfunction

endpackage

// File: rtl/input_mems_pp_if.sv
// AXI-Stream operand input: element data, set header in TUSER, ready/valid handshake.
interface input_mems_pp_if;

    logic signed [input_mems_pkg::INW-1:0] AXIS_TDATA;
    logic                                  AXIS_TVALID;
    logic [input_mems_pkg::K_BITS:0]       AXIS_TUSER;
    logic                                  AXIS_TREADY;

    modport master (
        output AXIS_TDATA,
        output AXIS_TVALID,
        output AXIS_TUSER,
        input  AXIS_TREADY
    );

    modport slave (
        input  AXIS_TDATA,
        input  AXIS_TVALID,
        input  AXIS_TUSER,
        output AXIS_TREADY
    );

endinterface

// File: rtl/bank_ram.sv
// Single operand bank: one write port, one registered read port (output cleared on reset).
module bank_ram #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SIZE  = 56,
    localparam int unsigned AW   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < SIZE)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Addresses past the bank depth read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (32'(i_raddr) < SIZE) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/input_mems_pp.sv
// Ping-pong A/B operand store: writer fills one slot from AXI-Stream while compute reads the other.
module input_mems_pp
    import input_mems_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input_mems_pp_if.slave          axis,
    output logic                    matrices_loaded,
    input  logic                    compute_finished,
    output logic [K_BITS-1:0]       K,
    input  logic [A_ADDR_BITS-1:0]  A_read_addr,
    output logic signed [INW-1:0]   A_data,
    input  logic [B_ADDR_BITS-1:0]  B_read_addr,
    output logic signed [INW-1:0]   B_data
);

    wstate_e r_wstate, w_wstate_nxt;
    rstate_e r_rstate, w_rstate_nxt;

    logic                r_wsel, r_rsel, r_a_cur, r_set_abank;
    logic [1:0]          r_full, r_abank;
    logic [K_BITS-1:0]   r_k [2];
    logic [K_BITS-1:0]   r_wk;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_asel, r_bsel;

    logic                w_tready, w_beat, w_new_a;
    logic                w_a_done, w_set_done, w_release;
    logic                w_a_we, w_b_we;
    logic [K_BITS-1:0]   w_k_in;
    logic [CNT_BITS-1:0] w_a_last, w_b_last, w_waddr;
    logic [INW-1:0]      w_a0, w_a1, w_b0, w_b1;

    assign w_new_a    = axis.AXIS_TUSER[0];
    assign w_k_in     = clamp_k(axis.AXIS_TUSER[K_BITS:1]);
    assign w_a_last   = CNT_BITS'(M * r_wk - 1);
    assign w_b_last   = CNT_BITS'(N * r_wk - 1);
    assign w_tready   = !reset && ((r_wstate != W_IDLE) || !r_full[r_wsel]);
    assign w_beat     = axis.AXIS_TVALID && w_tready;
    assign w_a_done   = (r_wstate == W_A) && w_beat && (r_cnt == w_a_last);
    assign w_set_done = (r_wstate == W_B) && w_beat && (r_cnt == w_b_last);
    assign w_release  = compute_finished && (r_rstate == R_LOADED);

    assign axis.AXIS_TREADY = w_tready;

    // Writer FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_beat) w_wstate_nxt = w_new_a ? W_A : W_B;
            W_A:     if (w_a_done) w_wstate_nxt = W_B;
            W_B:     if (w_set_done) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_a_we  = 1'b0;
        w_b_we  = 1'b0;
        w_waddr = r_cnt;
        unique case (r_wstate)
            W_IDLE: begin
                w_waddr = '0;
                w_a_we  = w_beat && w_new_a;
                w_b_we  = w_beat && !w_new_a;
            end
            W_A:     w_a_we = w_beat;
            W_B:     w_b_we = w_beat;
            default: ;
        endcase
    end

    // The header beat is element 0, so the counter resumes at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wsel      <= 1'b0;
            r_a_cur     <= 1'b0;
            r_set_abank <= 1'b0;
            r_wk        <= '0;
            r_cnt       <= '0;
        end else if (w_beat) begin
            unique case (r_wstate)
                W_IDLE: begin
                    r_wk        <= w_k_in;
                    r_cnt       <= CNT_BITS'(1);
                    r_set_abank <= w_new_a ? !r_a_cur : r_a_cur;
                end
                W_A: begin
                    if (w_a_done) begin
                        r_a_cur <= !r_a_cur;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                W_B: begin
                    if (w_set_done) begin
                        r_wsel <= !r_wsel;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Release and completion always hit different slots, so both may apply in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full  <= '0;
            r_abank <= '0;
            r_k[0]  <= '0;
            r_k[1]  <= '0;
        end else begin
            if (w_release) begin
                r_full[r_rsel] <= 1'b0;
            end
            if (w_set_done) begin
                r_full[r_wsel]  <= 1'b1;
                r_k[r_wsel]     <= r_wk;
                r_abank[r_wsel] <= r_set_abank;
            end
        end
    end

    // Reader FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_EMPTY;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_EMPTY: begin
                if (r_full[r_rsel] || (w_set_done && (r_wsel == r_rsel))) begin
                    w_rstate_nxt = R_LOADED;
                end
            end
            R_LOADED: if (compute_finished) w_rstate_nxt = R_EMPTY;
            default:  w_rstate_nxt = R_EMPTY;
        endcase
    end

    always_comb begin
        matrices_loaded = (r_rstate == R_LOADED);
        K               = matrices_loaded ? r_k[r_rsel] : '0;
    end

    // Bank selects are registered alongside the read address to keep 1-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsel <= 1'b0;
            r_asel <= 1'b0;
            r_bsel <= 1'b0;
        end else begin
            if (w_release) begin
                r_rsel <= !r_rsel;
            end
            r_asel <= r_abank[r_rsel];
            r_bsel <= r_rsel;
        end
    end

    bank_ram #(.WIDTH(INW), .SIZE(M * MAXK)) u_a0 (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_a_we && r_a_cur),
        .i_waddr (w_waddr[A_ADDR_BITS-1:0]),
        .i_wdata (axis.AXIS_TDATA),
        .i_raddr (A_read_addr),
        .o_rdata (w_a0)
    );

    bank_ram #(.WIDTH(INW), .SIZE(M * MAXK)) u_a1 (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_a_we && !r_a_cur),
        .i_waddr (w_waddr[A_ADDR_BITS-1:0]),
        .i_wdata (axis.AXIS_TDATA),
        .i_raddr (A_read_addr),
        .o_rdata (w_a1)
    );

    bank_ram #(.WIDTH(INW), .SIZE(MAXK * N)) u_b0 (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_b_we && !r_wsel),
        .i_waddr (w_waddr[B_ADDR_BITS-1:0]),
        .i_wdata (axis.AXIS_TDATA),
        .i_raddr (B_read_addr),
        .o_rdata (w_b0)
    );

    bank_ram #(.WIDTH(INW), .SIZE(MAXK * N)) u_b1 (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_b_we && r_wsel),
        .i_waddr (w_waddr[B_ADDR_BITS-1:0]),
        .i_wdata (axis.AXIS_TDATA),
        .i_raddr (B_read_addr),
        .o_rdata (w_b1)
    );

    assign A_data = r_asel ? w_a1 : w_a0;
    assign B_data = r_bsel ? w_b1 : w_b0;

endmodule

// File: tb/tb_input_mems_pp.sv
// Scoreboard bench for input_mems_pp: expected sets queued as streamed, compared on readout.
module tb_input_mems_pp;
    import input_mems_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   matrices_loaded;
    logic                   compute_finished = 1'b0;
    logic [K_BITS-1:0]      K;
    logic [A_ADDR_BITS-1:0] A_read_addr = '0;
    logic signed [INW-1:0]  A_data;
    logic [B_ADDR_BITS-1:0] B_read_addr = '0;
    logic signed [INW-1:0]  B_data;

    input_mems_pp_if axis ();

    input_mems_pp dut (
        .clk              (clk),
        .reset            (reset),
        .axis             (axis),
        .matrices_loaded  (matrices_loaded),
        .compute_finished (compute_finished),
        .K                (K),
        .A_read_addr      (A_read_addr),
        .A_data           (A_data),
        .B_read_addr      (B_read_addr),
        .B_data           (B_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int q_k[$];
    logic signed [INW-1:0] q_a[$];
    logic signed [INW-1:0] q_b[$];
    logic signed [INW-1:0] last_a[M*MAXK];
    int seq_val  = 1;
    bit seq_mode = 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [INW-1:0] gen_val();
        logic signed [INW-1:0] v;
        if (seq_mode) begin
            v = INW'(seq_val);
            seq_val++;
        end else begin
            v = INW'($urandom);
        end
        return v;
    endfunction

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic send_beat(input logic signed [INW-1:0] d, input logic [K_BITS:0] u,
                             input bit rnd, inout int stalls, inout bit ok);
        int w;
        if (!ok) return;
        if (rnd) begin
            while ($urandom_range(0, 2) == 0) begin
                axis.AXIS_TVALID = 1'b0;
                @(negedge clk);
            end
        end
        axis.AXIS_TVALID = 1'b1;
        axis.AXIS_TDATA  = d;
        axis.AXIS_TUSER  = u;
        w = 0;
        while (!axis.AXIS_TREADY) begin
            if (w == 500) begin
                check("tready_timeout", 0, 1);
                ok = 1'b0;
                axis.AXIS_TVALID = 1'b0;
                return;
            end
            @(negedge clk);
            w++;
            stalls++;
        end
        @(negedge clk);
        axis.AXIS_TVALID = 1'b0;
    endtask

    // b_limit < 0 streams a whole set and queues its expectations; otherwise stops early.
    task automatic send_set(input bit new_a, input int kraw, input bit rnd, input int b_limit,
                            output int stalls);
        int k, na, nb;
        bit ok, first;
        logic [K_BITS:0] u;
        logic signed [INW-1:0] av[M*MAXK];
        logic signed [INW-1:0] bv[MAXK*N];
        k = (kraw == 0) ? 1 : ((kraw > int'(MAXK)) ? int'(MAXK) : kraw);
        na = int'(M) * k;
        nb = int'(N) * k;
        u = {K_BITS'(kraw), new_a};
        stalls = 0;
        ok = 1'b1;
        first = 1'b1;
        for (int i = 0; i < na; i++) av[i] = new_a ? gen_val() : last_a[i];
        for (int i = 0; i < nb; i++) bv[i] = gen_val();
        if (new_a) begin
            for (int i = 0; i < na; i++) begin
                send_beat(av[i], first ? u : (K_BITS + 1)'($urandom), rnd, stalls, ok);
                first = 1'b0;
            end
        end
        for (int i = 0; i < nb; i++) begin
            if (b_limit < 0 || i < b_limit) begin
                send_beat(bv[i], first ? u : (K_BITS + 1)'($urandom), rnd, stalls, ok);
                first = 1'b0;
            end
        end
        if (b_limit < 0) begin
            if (new_a) for (int i = 0; i < na; i++) last_a[i] = av[i];
            q_k.push_back(k);
            for (int i = 0; i < na; i++) q_a.push_back(av[i]);
            for (int i = 0; i < nb; i++) q_b.push_back(bv[i]);
        end
    endtask

    task automatic wait_loaded();
        int w = 0;
        while (!matrices_loaded && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("loaded_wait", int'(matrices_loaded), 1);
    endtask

    task automatic read_set();
        int k;
        logic signed [INW-1:0] e, prev;
        if (q_k.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        k = q_k.pop_front();
        check("K", int'(K), k);
        for (int i = 0; i < int'(M) * k; i++) begin
            A_read_addr = A_ADDR_BITS'(i);
            if (i > 0) begin
                #1 check("A_latency", int'(A_data), int'(prev));
            end
            @(negedge clk);
            e = q_a.pop_front();
            check($sformatf("A_data[%0d]", i), int'(A_data), int'(e));
            prev = e;
        end
        for (int i = 0; i < int'(N) * k; i++) begin
            B_read_addr = B_ADDR_BITS'(i);
            @(negedge clk);
            e = q_b.pop_front();
            check($sformatf("B_data[%0d]", i), int'(B_data), int'(e));
        end
        check("loaded_hold", int'(matrices_loaded), 1);
    endtask

    task automatic release_set();
        compute_finished = 1'b1;
        @(negedge clk);
        compute_finished = 1'b0;
        check("release_low", int'(matrices_loaded), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int st, st3;
        axis.AXIS_TVALID = 1'b0;
        axis.AXIS_TDATA  = '0;
        axis.AXIS_TUSER  = '0;
        for (int i = 0; i < int'(M * MAXK); i++) last_a[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_tready", int'(axis.AXIS_TREADY), 0);
        check("reset_loaded", int'(matrices_loaded), 0);
        check("reset_K", int'(K), 0);
        check("reset_A_data", int'(A_data), 0);
        check("reset_B_data", int'(B_data), 0);
        reset = 1'b0;
        #1 check("tready_after_reset", int'(axis.AXIS_TREADY), 1);
        @(negedge clk);

        // Set 1: new_A, K=2, values 1..32
        send_set(1'b1, 2, 1'b0, -1, st);
        check("set1_stalls", st, 0);
        check("loaded_rise", int'(matrices_loaded), 1);
        seq_mode = 1'b0;
        read_set();

        // Set 2 overlaps compute on set 1
        send_set(1'b1, 3, 1'b0, -1, st);
        check("set2_stalls", st, 0);

        // Set 3 (reuses set 2's A) must stall until set 1 is released
        fork
            send_set(1'b0, 2, 1'b1, -1, st3);
            begin
                repeat (6) @(negedge clk);
                check("tready_stall", int'(axis.AXIS_TREADY), 0);
                check("loaded_during_stall", int'(matrices_loaded), 1);
                compute_finished = 1'b1;
                @(negedge clk);
                compute_finished = 1'b0;
                check("gap_low", int'(matrices_loaded), 0);
                @(negedge clk);
                check("gap_high", int'(matrices_loaded), 1);
            end
        join
        check("set3_stalled", int'(st3 > 0), 1);
        read_set();
        release_set();
        wait_loaded();
        read_set();
        release_set();

        // Random TVALID, K=4
        send_set(1'b1, 4, 1'b1, -1, st);
        wait_loaded();
        read_set();
        release_set();

        // K=0 clamps to 1; K=12 clamps to MAXK
        send_set(1'b1, 0, 1'b1, -1, st);
        wait_loaded();
        read_set();
        release_set();
        send_set(1'b1, 12, 1'b1, -1, st);
        wait_loaded();
        read_set();
        release_set();

        // Reset partway through the B stream
        send_set(1'b1, 2, 1'b1, 5, st);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tready", int'(axis.AXIS_TREADY), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_no_loaded", int'(matrices_loaded), 0);
        send_set(1'b1, 1, 1'b0, -1, st);
        check("post_reset_loaded", int'(matrices_loaded), 1);
        read_set();
        release_set();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
